// File: rtl/pra_msg_if.sv
// Byte stream in, message-detect status out, between the detector and its source.
interface pra_msg_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       data_in;
  logic             data_valid;
  logic             match;
  logic             msg_id;
  logic [CNT_W-1:0] match_count;
  logic             locked;
  logic             err;

  modport master (
    output data_in, data_valid,
    input  match, msg_id, match_count, locked, err
  );

  modport slave (
    input  data_in, data_valid,
    output match, msg_id, match_count, locked, err
  );
endinterface

// File: rtl/pra_msg_detector.sv
// Recognises "Guatemala" (id 0) and "QQuetza" (id 1) in a byte stream.
// It counts completions and locks onto a message that repeats back-to-back.
module pra_msg_detector #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 2
) (
  input logic      clk,
  input logic      reset,
  pra_msg_if.slave bus
);
  // state  | meaning
  // SEARCH | hunting for a back-to-back repeating message
  // LOCKED | lock_id repeating; any byte off its sequence raises err
  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  function automatic logic [7:0] g_char(input logic [3:0] idx);
    case (idx)
      4'd0:    g_char = 8'h47;
      4'd1:    g_char = 8'h75;
      4'd2:    g_char = 8'h61;
      4'd3:    g_char = 8'h74;
      4'd4:    g_char = 8'h65;
      4'd5:    g_char = 8'h6D;
      4'd6:    g_char = 8'h61;
      4'd7:    g_char = 8'h6C;
      default: g_char = 8'h61;
    endcase
  endfunction

  function automatic logic [7:0] q_char(input logic [2:0] idx);
    case (idx)
      3'd0:    q_char = 8'h51;
      3'd1:    q_char = 8'h51;
      3'd2:    q_char = 8'h75;
      3'd3:    q_char = 8'h65;
      3'd4:    q_char = 8'h74;
      3'd5:    q_char = 8'h7A;
      default: q_char = 8'h61;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       gidx_q, gidx_d;
  logic [2:0]       qidx_q, qidx_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]       streak_q, streak_d;
  logic             last_id_q, last_id_d;
  logic             lock_id_q, lock_id_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, err_q;

  logic       g_hit, q_hit, g_done, q_done, done, done_id, brk;
  logic [3:0] cnt_inc, len;
  logic [7:0] lock_exp;

  always_comb begin
    g_hit    = (bus.data_in == g_char(gidx_q));
    q_hit    = (bus.data_in == q_char(qidx_q));
    g_done   = bus.data_valid && g_hit && (gidx_q == 4'd8);
    q_done   = bus.data_valid && q_hit && (qidx_q == 3'd6);
    done     = g_done || q_done;
    done_id  = !g_done;
    len      = done_id ? 4'd7 : 4'd9;
    cnt_inc  = (byte_cnt_q == 4'hF) ? 4'hF : byte_cnt_q + 4'd1;
    lock_exp = lock_id_q ? q_char(qidx_q) : g_char(gidx_q);
    brk      = bus.data_valid && (state_q == LOCKED) && (bus.data_in != lock_exp);

    gidx_d     = gidx_q;
    qidx_d     = qidx_q;
    byte_cnt_d = byte_cnt_q;
    streak_d   = streak_q;
    last_id_d  = last_id_q;
    lock_id_d  = lock_id_q;
    count_d    = count_q;
    state_d    = state_q;

    if (bus.data_valid) begin
      if (g_hit)                       gidx_d = (gidx_q == 4'd8) ? 4'd0 : gidx_q + 4'd1;
      else if (bus.data_in == 8'h47)   gidx_d = 4'd1;
      else                             gidx_d = 4'd0;

      // "QQQ..." keeps the last two Q's as a valid prefix
      if (q_hit)                       qidx_d = (qidx_q == 3'd6) ? 3'd0 : qidx_q + 3'd1;
      else if (bus.data_in == 8'h51)   qidx_d = (qidx_q == 3'd2) ? 3'd2 : 3'd1;
      else                             qidx_d = 3'd0;

      byte_cnt_d = done ? 4'd0 : cnt_inc;
    end

    if (done) begin
      if (done_id == last_id_q && streak_q != 4'd0 && cnt_inc == len)
        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
      else
        streak_d = 4'd1;
      last_id_d = done_id;
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
    end
    if (brk) streak_d = 4'd0;

    case (state_q)
      SEARCH: if (done && streak_d >= LOCK_V) begin
        state_d   = LOCKED;
        lock_id_d = done_id;
      end
      LOCKED: if (brk) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      gidx_q     <= 4'd0;
      qidx_q     <= 3'd0;
      byte_cnt_q <= 4'd0;
      streak_q   <= 4'd0;
      last_id_q  <= 1'b0;
      lock_id_q  <= 1'b0;
      count_q    <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      qidx_q     <= qidx_d;
      byte_cnt_q <= byte_cnt_d;
      streak_q   <= streak_d;
      last_id_q  <= last_id_d;
      lock_id_q  <= lock_id_d;
      count_q    <= count_d;
      match_q    <= done;
      err_q      <= brk;
    end
  end

  assign bus.match       = match_q;
  assign bus.msg_id      = last_id_q;
  assign bus.match_count = count_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.err         = err_q;
endmodule
